bam_op_sequencer: RTL and testbench

- Control stage directly upstream of the integrated Booth multiplier (input registers A/B, Booth core, output register).
- Accepts signed operand pairs over a valid/ready handshake and sequences the multiplier's per-register enables and resets.
- Captures the 64-bit product and presents it downstream over a valid/ready handshake, with a 32-bit-fit flag and an operation counter.
- Replaces hand-timed enable pulsing with a single FSM.

---
 rtl/bam_op_sequencer.sv | 124 ++++++++++++
 tb/tb_bam_op_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bam_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bam_op_sequencer
// Brief    : Control stage in front of the Booth multiplier. Accepts signed
//            operand pairs over valid/ready, sequences the multiplier's
//            register enables and clears, and returns the 2*WIDTH-bit product
//            downstream with a 32-bit fit flag and a completed-op counter.
// Revision : 1.0 - initial release
// ============================================================================
module bam_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int OUT_LAT       = 2,
  parameter int CLEAR_BETWEEN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_fits32,
  output logic [15:0]          op_count,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_enableA,
  output logic                 mul_enableB,
  output logic                 mul_enableOut,
  output logic                 mul_resetA,
  output logic                 mul_resetB,
  output logic                 mul_resetOut,
  input  logic [2*WIDTH-1:0]   mul_product
);

  // Counter preload: EXEC lasts OUT_LAT cycles, counting down to zero.
  localparam logic [3:0] c_lat_init = 4'(OUT_LAT - 1);
  localparam int         c_fit_lsb  = 31;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_EXEC    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4,
    S_CLEAR   = 3'd5
  } state_t;

  state_t     r_state;
  logic [3:0] r_lat_cnt;
  logic       w_fits;
  logic       w_out_fire;

  // Product fits a 32-bit signed value when all bits from bit 31 upward agree.
  assign w_fits     = (&mul_product[2*WIDTH-1:c_fit_lsb]) |
                      ~(|mul_product[2*WIDTH-1:c_fit_lsb]);
  assign w_out_fire = (r_state == S_DONE) && out_ready;

  // Handshake flags and multiplier enables are decoded from the state register.
  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign mul_enableA   = (r_state == S_LOAD);
  assign mul_enableB   = (r_state == S_LOAD);
  assign mul_enableOut = (r_state == S_EXEC);

  // Multiplier clears follow reset directly so the datapath is cleared alongside us.
  assign mul_resetA   = reset | (r_state == S_CLEAR);
  assign mul_resetB   = reset | (r_state == S_CLEAR);
  assign mul_resetOut = reset | (r_state == S_CLEAR);

  // Main sequencing FSM with its operand, latency and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= 4'd0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_product <= '0;
      out_fits32  <= 1'b1;
      op_count    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            mul_a   <= in_a;
            mul_b   <= in_b;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_lat_cnt <= c_lat_init;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (r_lat_cnt == 4'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          out_product <= mul_product;
          out_fits32  <= w_fits;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (w_out_fire) begin
            op_count <= op_count + 16'd1;
            r_state  <= (CLEAR_BETWEEN != 0) ? S_CLEAR : S_IDLE;
          end
        end
        S_CLEAR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bam_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bam_op_sequencer
// Brief    : Directed bench for bam_op_sequencer with a behavioural Booth
//            multiplier (registers A/B/Out) attached on the mul_* side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bam_op_sequencer;

  localparam int WIDTH = 32;
  localparam int OUT_LAT = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                out_valid;
  logic                out_ready;
  logic [2*WIDTH-1:0]  out_product;
  logic                out_fits32;
  logic [15:0]         op_count;
  logic [WIDTH-1:0]    mul_a;
  logic [WIDTH-1:0]    mul_b;
  logic                mul_enableA;
  logic                mul_enableB;
  logic                mul_enableOut;
  logic                mul_resetA;
  logic                mul_resetB;
  logic                mul_resetOut;
  logic [2*WIDTH-1:0]  mul_product;

  bam_op_sequencer #(.WIDTH(WIDTH), .OUT_LAT(OUT_LAT), .CLEAR_BETWEEN(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_fits32(out_fits32), .op_count(op_count),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_enableA(mul_enableA), .mul_enableB(mul_enableB), .mul_enableOut(mul_enableOut),
    .mul_resetA(mul_resetA), .mul_resetB(mul_resetB), .mul_resetOut(mul_resetOut),
    .mul_product(mul_product)
  );

  always #10 clk = ~clk;

  // Behavioural multiplier: input registers A/B and a product register.
  logic signed [WIDTH-1:0] r_ma;
  logic signed [WIDTH-1:0] r_mb;
  logic [2*WIDTH-1:0]      r_mout;
  always @(posedge clk) begin
    if (mul_resetA) r_ma <= '0; else if (mul_enableA) r_ma <= mul_a;
    if (mul_resetB) r_mb <= '0; else if (mul_enableB) r_mb <= mul_b;
    if (mul_resetOut) r_mout <= '0;
    else if (mul_enableOut) r_mout <= 64'(longint'(r_ma) * longint'(r_mb));
  end
  assign mul_product = r_mout;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        fits;
    int          hold;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one operation from accept to return-to-IDLE, checking cycle timing.
  task automatic run_op(input vec_t v, input logic [15:0] exp_cnt);
    int waitc;
    int en_a;
    int en_b;
    int en_o;
    waitc = 0;
    en_a = 0; en_b = 0; en_o = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    in_a = v.a; in_b = v.b; in_valid = 1'b1;
    out_ready = (v.hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul_a_latched", 64'(mul_a), 64'(v.a));
    chk("mul_b_latched", 64'(mul_b), 64'(v.b));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      en_a += int'(mul_enableA);
      en_b += int'(mul_enableB);
      en_o += int'(mul_enableOut);
    end
    chk("valid_early", 64'(out_valid), 64'd0);
    chk("enA_cycles", 64'(en_a), 64'd1);
    chk("enB_cycles", 64'(en_b), 64'd1);
    chk("enOut_cycles", 64'(en_o), 64'(OUT_LAT));
    @(negedge clk);
    chk("valid_latency", 64'(out_valid), 64'd1);
    chk("product", out_product, v.p);
    chk("fits32", 64'(out_fits32), 64'(v.fits));
    for (int h = 0; h < v.hold; h++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_product", out_product, v.p);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      in_valid = (h == 1);
      in_a = 32'd7; in_b = 32'd7;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("pre_hs_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("op_count", 64'(op_count), 64'(exp_cnt));
    chk("clear_pulse", 64'({mul_resetA, mul_resetB, mul_resetOut}), 64'd7);
    chk("clear_keeps_product", out_product, v.p);
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("clear_done", 64'(mul_resetOut), 64'd0);
    chk("mul_cleared", mul_product, 64'd0);
    chk("mul_a_held", 64'(mul_a), 64'(v.a));
    if (v.hold > 0) begin
      @(negedge clk);
      chk("stray_ignored", 64'({in_ready, mul_enableA}), 64'd2);
      chk("count_once", 64'(op_count), 64'(exp_cnt));
    end
  endtask

  initial begin
    vecs[0] = '{a: 32'd5,          b: 32'd6,          p: 64'd30,                 fits: 1'b1, hold: 0};
    vecs[1] = '{a: 32'hFFFFFFFC,   b: 32'hFFFFFFF9,   p: 64'd28,                 fits: 1'b1, hold: 0};
    vecs[2] = '{a: 32'd10,         b: 32'hFFFFFFFC,   p: 64'hFFFFFFFFFFFFFFD8,   fits: 1'b1, hold: 0};
    vecs[3] = '{a: 32'hFFFFFFCE,   b: 32'd5,          p: 64'hFFFFFFFFFFFFFF06,   fits: 1'b1, hold: 0};
    vecs[4] = '{a: 32'h80000000,   b: 32'h80000000,   p: 64'h4000000000000000,   fits: 1'b0, hold: 0};
    vecs[5] = '{a: 32'd1234,       b: 32'd0,          p: 64'd0,                  fits: 1'b1, hold: 3};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", out_product, 64'd0);
    chk("rst_fits32", 64'(out_fits32), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
    chk("rst_enables", 64'({mul_enableA, mul_enableB, mul_enableOut}), 64'd0);
    chk("rst_mul_resets", 64'({mul_resetA, mul_resetB, mul_resetOut}), 64'd7);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i], 16'(i + 1));
    end

    // Reset during EXEC of 99 x 1 discards the operation and clears op_count.
    in_a = 32'd99; in_b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("exec_reached", 64'(mul_enableOut), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset_comb_clear", 64'({mul_resetA, mul_resetB, mul_resetOut}), 64'd7);
    @(negedge clk);
    chk("midrst_idle", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(op_count), 64'd0);
    chk("midrst_enOut", 64'(mul_enableOut), 64'd0);
    chk("midrst_product", out_product, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_clear_off", 64'(mul_resetOut), 64'd0);
    run_op('{a: 32'd32, b: 32'd23, p: 64'd736, fits: 1'b1, hold: 0}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
